mac_vector_unit: RTL and testbench

- Multi-lane INT multiply-accumulate engine for the NPU compute array; successor to the scalar MAC.
- Each beat computes a LANES-wide dot product of activations and weights and accumulates it across a packet delimited by first/last.
- Per-beat signed/unsigned operand modes and optional saturation.
- 2-stage pipeline with valid/ready on input and output; result is held until consumed.

---
 rtl/mac_vector_unit.sv | 129 ++++++++++++
 tb/tb_mac_vector_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_vector_unit.sv
// Multi-lane multiply-accumulate engine: per-beat LANES-wide dot product accumulated
// across a first/last-delimited packet, with signed/unsigned operands and optional saturation.
`default_nettype none

module mac_vector_unit #(
  parameter int LANES = 4,
  parameter int IN_W  = 8,
  parameter int WT_W  = 8,
  parameter int ACC_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [LANES*IN_W-1:0] in_data,
  input  logic [LANES*WT_W-1:0] in_weight,
  input  logic                  data_signed,
  input  logic                  weight_signed,
  input  logic                  sat_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic                  out_sat
);

  localparam int P      = IN_W + WT_W + 2;
  localparam int SUM_W  = P + $clog2(LANES);
  // Wide enough for base + sum even when ACC_W is narrower than the lane sum.
  localparam int WIDE_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

  logic adv;
  logic accept;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  logic signed [P-1:0] prod [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic signed [IN_W:0] a_ext;
    logic signed [WT_W:0] w_ext;
    assign a_ext   = {data_signed & in_data[i*IN_W+IN_W-1], in_data[i*IN_W +: IN_W]};
    assign w_ext   = {weight_signed & in_weight[i*WT_W+WT_W-1], in_weight[i*WT_W +: WT_W]};
    assign prod[i] = P'(a_ext) * P'(w_ext);
  end

  logic                s1_valid;
  logic                s1_first;
  logic                s1_last;
  logic                s1_sat;
  logic signed [P-1:0] s1_prod [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_sat   <= 1'b0;
      for (int i = 0; i < LANES; i++) s1_prod[i] <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      if (accept) begin
        s1_first <= in_first;
        s1_last  <= in_last;
        s1_sat   <= sat_en;
        for (int i = 0; i < LANES; i++) s1_prod[i] <= prod[i];
      end
    end
  end

  logic signed [ACC_W-1:0]  acc;
  logic                     sticky;
  logic signed [SUM_W-1:0]  lane_sum;
  logic signed [WIDE_W-1:0] base;
  logic signed [WIDE_W-1:0] wide;
  logic                     pos_ovf;
  logic                     neg_ovf;
  logic                     sat_hit;
  logic [ACC_W-1:0]         result;
  logic                     sticky_nxt;

  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) lane_sum = lane_sum + SUM_W'(s1_prod[i]);
  end

  assign base    = s1_first ? '0 : WIDE_W'(acc);
  assign wide    = base + WIDE_W'(lane_sum);
  // Out of range when the bits above the ACC_W sign bit disagree with the top bit.
  assign pos_ovf = !wide[WIDE_W-1] && (|wide[WIDE_W-2:ACC_W-1]);
  assign neg_ovf = wide[WIDE_W-1] && !(&wide[WIDE_W-2:ACC_W-1]);
  assign sat_hit = s1_sat && (pos_ovf || neg_ovf);

  always_comb begin
    result = wide[ACC_W-1:0];
    if (sat_hit) result = pos_ovf ? {1'b0, {(ACC_W-1){1'b1}}} : {1'b1, {(ACC_W-1){1'b0}}};
  end

  assign sticky_nxt = (!s1_first && sticky) || sat_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      sticky    <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid && s1_last;
      if (s1_valid) begin
        if (s1_last) begin
          acc      <= '0;
          sticky   <= 1'b0;
          out_data <= result;
          out_sat  <= sticky_nxt;
        end else begin
          acc      <= result;
          sticky   <= sticky_nxt;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mac_vector_unit.sv
// Bench for mac_vector_unit: directed test-plan cases plus randomized packets checked
// against a packet-level arithmetic model for a 32-bit and a 16-bit accumulator instance.
`default_nettype none

module tb_mac_vector_unit;

  localparam int LANES = 4;
  localparam int IN_W  = 8;
  localparam int WT_W  = 8;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid, in_first, in_last;
  logic [LANES*IN_W-1:0] in_data;
  logic [LANES*WT_W-1:0] in_weight;
  logic                  data_signed, weight_signed, sat_en, out_ready;
  logic                  in_ready, out_valid, out_sat;
  logic [31:0]           out_data;
  logic                  in_ready16, out_valid16, out_sat16;
  logic [15:0]           out_data16;

  always #5 clk = ~clk;

  mac_vector_unit #(.LANES(LANES), .IN_W(IN_W), .WT_W(WT_W), .ACC_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .in_weight(in_weight),
    .data_signed(data_signed), .weight_signed(weight_signed), .sat_en(sat_en),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
  );

  mac_vector_unit #(.LANES(LANES), .IN_W(IN_W), .WT_W(WT_W), .ACC_W(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
    .in_first(in_first), .in_last(in_last), .in_data(in_data), .in_weight(in_weight),
    .data_signed(data_signed), .weight_signed(weight_signed), .sat_en(sat_en),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .out_sat(out_sat16)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: one accumulator per instance width, expected results queued per packet.
  int      acc_w [2] = '{32, 16};
  longint  m_acc [2];
  bit      m_sticky [2];
  longint  q_res [2][$];
  bit      q_sat [2][$];
  bit      acc_flag;

  function automatic longint dot(input logic [31:0] d, input logic [31:0] w, input bit ds, input bit ws);
    longint s;
    logic [7:0] a, b;
    s = 0;
    for (int i = 0; i < LANES; i++) begin
      a = d[i*8 +: 8];
      b = w[i*8 +: 8];
      s += (ds ? longint'($signed(a)) : longint'(a)) * (ws ? longint'($signed(b)) : longint'(b));
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_acc[k] = 0;
      m_sticky[k] = 0;
      q_res[k].delete();
      q_sat[k].delete();
    end
  endtask

  task automatic model_beat();
    longint sum, hi, lo, wide, span;
    bit st;
    sum = dot(in_data, in_weight, data_signed, weight_signed);
    for (int k = 0; k < 2; k++) begin
      span = longint'(1) << acc_w[k];
      hi   = (span >> 1) - 1;
      lo   = -(span >> 1);
      wide = (in_first ? 0 : m_acc[k]) + sum;
      st   = in_first ? 1'b0 : m_sticky[k];
      if (sat_en) begin
        if (wide > hi) begin wide = hi; st = 1'b1; end
        else if (wide < lo) begin wide = lo; st = 1'b1; end
      end else begin
        wide = wide & (span - 1);
        if (wide > hi) wide -= span;
      end
      if (in_last) begin
        q_res[k].push_back(wide);
        q_sat[k].push_back(st);
        m_acc[k] = 0;
        m_sticky[k] = 0;
      end else begin
        m_acc[k] = wide;
        m_sticky[k] = st;
      end
    end
  endtask

  task automatic consume();
    longint e;
    for (int k = 0; k < 2; k++) begin
      if (q_res[k].size() == 0) begin
        check(k == 0 ? "unexpected_out32" : "unexpected_out16", 1, 0);
      end else begin
        e = q_res[k].pop_front() & ((longint'(1) << acc_w[k]) - 1);
        if (k == 0) begin
          check("sb_data32", {32'b0, out_data}, e);
          check("sb_sat32", out_sat, q_sat[k].pop_front());
        end else begin
          check("sb_valid16", out_valid16, 1);
          check("sb_data16", {48'b0, out_data16}, e);
          check("sb_sat16", out_sat16, q_sat[k].pop_front());
        end
      end
    end
  endtask

  // Called just after a falling edge with inputs driven; returns at the next falling edge.
  task automatic tick();
    #1;
    acc_flag = in_valid && in_ready;
    if (acc_flag) model_beat();
    if (out_valid && out_ready) consume();
    @(negedge clk);
  endtask

  task automatic drive_beat(input bit f, input bit l, input logic [7:0] d, input logic [7:0] w,
                            input bit ds, input bit ws, input bit sat);
    in_valid = 1; in_first = f; in_last = l;
    in_data = {LANES{d}}; in_weight = {LANES{w}};
    data_signed = ds; weight_signed = ws; sat_en = sat;
  endtask

  task automatic idle();
    in_valid = 0; in_first = 0; in_last = 0;
  endtask

  task automatic single(input string tag, input logic [7:0] d, input logic [7:0] w, input bit ds,
                        input bit ws, input bit sat, input logic [31:0] e32, input bit es32,
                        input bit chk16, input logic [15:0] e16, input bit es16);
    drive_beat(1, 1, d, w, ds, ws, sat);
    tick();
    check({tag, "_lat1"}, out_valid, 0);
    idle();
    tick();
    check({tag, "_lat2"}, out_valid, 1);
    check({tag, "_data32"}, {32'b0, out_data}, {32'b0, e32});
    check({tag, "_sat32"}, out_sat, es32);
    if (chk16) begin
      check({tag, "_data16"}, {48'b0, out_data16}, {48'b0, e16});
      check({tag, "_sat16"}, out_sat16, es16);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 0; out_ready = 1; acc_flag = 0;
    idle(); in_data = '0; in_weight = '0; data_signed = 0; weight_signed = 0; sat_en = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", {32'b0, out_data}, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_in_ready16", in_ready16, 1);
    rst_n = 1;
    @(negedge clk);

    single("t1_signed", 8'h7F, 8'h7F, 1, 1, 0, 32'h0000FC04, 0, 1, 16'hFC04, 0);
    single("t4_sat", 8'h7F, 8'h7F, 1, 1, 1, 32'h0000FC04, 0, 1, 16'h7FFF, 1);
    single("t4_clr", 8'h01, 8'h01, 1, 1, 1, 32'h00000004, 0, 1, 16'h0004, 0);
    single("t2_uu", 8'hFF, 8'hFF, 0, 0, 0, 32'h0003F804, 0, 0, 16'h0, 0);
    single("t2_us", 8'hFF, 8'h80, 0, 1, 0, 32'hFFFE0200, 0, 0, 16'h0, 0);

    // Three-beat packet with two idle cycles between beats.
    for (int b = 0; b < 3; b++) begin
      drive_beat(b == 0, b == 2, 8'h02, 8'hFD, 1, 1, 0);
      tick();
      check("t3_no_early_out", out_valid, 0);
      if (b < 2) begin
        idle();
        repeat (2) tick();
      end
    end
    idle();
    tick();
    check("t3_valid", out_valid, 1);
    check("t3_data", {32'b0, out_data}, 64'h00000000FFFFFFB8);
    tick();

    // Backpressure: A (1x2 -> 8) then B (3x3 -> 36) with the consumer stalled.
    out_ready = 0;
    drive_beat(1, 1, 8'h01, 8'h02, 0, 0, 0);
    tick();
    drive_beat(1, 1, 8'h03, 8'h03, 0, 0, 0);
    tick();
    idle();
    check("t5_stall_ready", in_ready, 0);
    check("t5_a_valid", out_valid, 1);
    repeat (3) tick();
    check("t5_a_hold", {32'b0, out_data}, 8);
    check("t5_stall_ready2", in_ready, 0);
    out_ready = 1;
    tick();
    out_ready = 0;
    check("t5_b_valid", out_valid, 1);
    check("t5_b_data", {32'b0, out_data}, 36);
    repeat (2) tick();
    out_ready = 1;
    tick();
    check("t5_drained", out_valid, 0);

    // Reset mid-packet after two of four beats.
    drive_beat(1, 0, 8'h02, 8'h02, 0, 0, 0);
    tick();
    drive_beat(0, 0, 8'h02, 8'h02, 0, 0, 0);
    tick();
    idle();
    tick();
    #2 rst_n = 0;
    #1;
    check("t6_data", {32'b0, out_data}, 0);
    check("t6_data16", {48'b0, out_data16}, 0);
    check("t6_valid", out_valid, 0);
    check("t6_sat16", out_sat16, 0);
    check("t6_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    @(negedge clk);
    drive_beat(0, 1, 8'h01, 8'h01, 0, 0, 0);
    tick();
    idle();
    tick();
    check("t6_own_only", {32'b0, out_data}, 4);
    tick();

    // Randomized packets with random bubbles and backpressure.
    idle();
    acc_flag = 0;
    for (int n = 0; n < 600; n++) begin
      if (!in_valid || acc_flag) begin
        in_valid      = ($urandom_range(0, 9) < 7);
        in_first      = ($urandom_range(0, 3) == 0);
        in_last       = ($urandom_range(0, 3) == 0);
        in_data       = $urandom;
        in_weight     = $urandom;
        data_signed   = $urandom_range(0, 1);
        weight_signed = $urandom_range(0, 1);
        sat_en        = $urandom_range(0, 1);
      end
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    idle();
    out_ready = 1;
    repeat (6) tick();
    check("drain_q32", q_res[0].size(), 0);
    check("drain_q16", q_res[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
